// File: rtl/alu_pkg.sv
// Shared definitions for the logic-ALU pipeline: operation encoding and its width.
package alu_pkg;

    localparam int unsigned ALU_LOG_OP_WIDTH = 3;

    typedef enum logic [ALU_LOG_OP_WIDTH-1:0] {
        ALU_LOG_AND   = 3'd0,
        ALU_LOG_OR    = 3'd1,
        ALU_LOG_XOR   = 3'd2,
        ALU_LOG_NOR   = 3'd3,
        ALU_LOG_BIC   = 3'd4,
        ALU_LOG_ORN   = 3'd5,
        ALU_LOG_EON   = 3'd6,
        ALU_LOG_PASSB = 3'd7
    } alu_log_op_e;

endpackage

// File: rtl/alu_pipe_stage.sv
// Single valid/ready register slice: loads whenever it is empty or its consumer takes the
// current contents, so a chain of these streams one beat per cycle with no bubbles.
module alu_pipe_stage #(
    parameter int unsigned      WIDTH      = 8,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             up_valid,
    output logic             up_ready_c,
    input  logic [WIDTH-1:0] up_data,
    output logic             dn_valid,
    input  logic             dn_ready,
    output logic [WIDTH-1:0] dn_data
);

    logic load_c;

    assign load_c     = !dn_valid || dn_ready;
    assign up_ready_c = load_c;

    // Payload only moves on a real upstream beat so an idle slot keeps its last value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dn_valid <= 1'b0;
            dn_data  <= RESET_DATA;
        end else if (load_c) begin
            dn_valid <= up_valid;
            if (up_valid) begin
                dn_data <= up_data;
            end
        end
    end

endmodule

// File: rtl/alu_logic_pipe.sv
// Two-stage bitwise logic ALU: S1 registers the operation, S2 registers the result with
// zero/negative flags and the caller's tag. Full valid/ready flow control on both sides.
module alu_logic_pipe
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned TAG_WIDTH  = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_WIDTH-1:0]       in_a,
    input  logic [DATA_WIDTH-1:0]       in_b,
    input  logic [ALU_LOG_OP_WIDTH-1:0] in_op,
    input  logic [TAG_WIDTH-1:0]        in_tag,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_WIDTH-1:0]       out_result,
    output logic                        out_zero,
    output logic                        out_neg,
    output logic [TAG_WIDTH-1:0]        out_tag
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;
        alu_log_op_e           op;
        logic [TAG_WIDTH-1:0]  tag;
    } op_pkt_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] result;
        logic                  zero;
        logic                  neg;
        logic [TAG_WIDTH-1:0]  tag;
    } res_pkt_t;

    localparam int unsigned OP_PKT_W  = $bits(op_pkt_t);
    localparam int unsigned RES_PKT_W = $bits(res_pkt_t);

    // An empty result register reads as a zero result: flag zero set, tag cleared.
    localparam logic [RES_PKT_W-1:0] RES_RESET = {DATA_WIDTH'(0), 1'b1, 1'b0, TAG_WIDTH'(0)};

    op_pkt_t               s1_in;
    op_pkt_t               s1_q;
    logic                  s1_valid;
    logic                  s1_ready_c;
    res_pkt_t              s2_in;
    res_pkt_t              s2_q;
    logic                  s2_valid;
    logic                  s2_ready_c;
    logic [DATA_WIDTH-1:0] logic_c;

    assign s1_in.a   = in_a;
    assign s1_in.b   = in_b;
    assign s1_in.op  = alu_log_op_e'(in_op);
    assign s1_in.tag = in_tag;

    // Ready is forced low while reset is asserted so nothing is offered acceptance then.
    assign in_ready = rst_n && s1_ready_c;

    alu_pipe_stage #(
        .WIDTH      (OP_PKT_W),
        .RESET_DATA (OP_PKT_W'(0))
    ) u_s1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .up_valid   (in_valid),
        .up_ready_c (s1_ready_c),
        .up_data    (s1_in),
        .dn_valid   (s1_valid),
        .dn_ready   (s2_ready_c),
        .dn_data    (s1_q)
    );

    // Operation decode between the two register stages.
    always_comb begin
        logic_c = s1_q.b;
        case (s1_q.op)
            ALU_LOG_AND:   logic_c = s1_q.a & s1_q.b;
            ALU_LOG_OR:    logic_c = s1_q.a | s1_q.b;
            ALU_LOG_XOR:   logic_c = s1_q.a ^ s1_q.b;
            ALU_LOG_NOR:   logic_c = ~(s1_q.a | s1_q.b);
            ALU_LOG_BIC:   logic_c = s1_q.a & ~s1_q.b;
            ALU_LOG_ORN:   logic_c = s1_q.a | ~s1_q.b;
            ALU_LOG_EON:   logic_c = s1_q.a ^ ~s1_q.b;
            ALU_LOG_PASSB: logic_c = s1_q.b;
            default:       logic_c = s1_q.b;
        endcase
    end

    assign s2_in.result = logic_c;
    assign s2_in.zero   = (logic_c == '0);
    assign s2_in.neg    = logic_c[DATA_WIDTH-1];
    assign s2_in.tag    = s1_q.tag;

    alu_pipe_stage #(
        .WIDTH      (RES_PKT_W),
        .RESET_DATA (RES_RESET)
    ) u_s2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .up_valid   (s1_valid),
        .up_ready_c (s2_ready_c),
        .up_data    (s2_in),
        .dn_valid   (s2_valid),
        .dn_ready   (out_ready),
        .dn_data    (s2_q)
    );

    assign out_valid  = s2_valid;
    assign out_result = s2_q.result;
    assign out_zero   = s2_q.zero;
    assign out_neg    = s2_q.neg;
    assign out_tag    = s2_q.tag;

endmodule

// File: tb/tb_alu_logic_pipe.sv
// Scoreboard bench for alu_logic_pipe: accepted operations push a model result, the output
// monitor pops and compares; directed cases cover latency, flags, back-pressure and reset.
module tb_alu_logic_pipe;

    localparam int unsigned DW   = 64;
    localparam int unsigned TW   = 4;
    localparam int          NOPS = 10000;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_a;
    logic [DW-1:0] in_b;
    logic [2:0]    in_op;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_result;
    logic          out_zero;
    logic          out_neg;
    logic [TW-1:0] out_tag;

    alu_logic_pipe #(
        .DATA_WIDTH (DW),
        .TAG_WIDTH  (TW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_neg    (out_neg),
        .out_tag    (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] r;
        logic          z;
        logic          n;
        logic [TW-1:0] t;
    } exp_t;

    exp_t          exp_q[$];
    logic [TW-1:0] log_tag[$];
    int            log_cyc[$];
    int            checks = 0;
    int            errors = 0;
    int            n_acc  = 0;
    int            n_out  = 0;
    int            cyc    = 0;
    logic          acc_now = 1'b0;
    logic          prev_stall = 1'b0;
    logic [DW+TW+2:0] prev_out = '0;
    exp_t          mon_e;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: the op table applied to whole words, flags derived from the word.
    function automatic exp_t model(input logic [2:0] op, input logic [DW-1:0] a,
                                   input logic [DW-1:0] b, input logic [TW-1:0] t);
        exp_t e;
        case (op)
            3'd0:    e.r = a & b;
            3'd1:    e.r = a | b;
            3'd2:    e.r = a ^ b;
            3'd3:    e.r = ~(a | b);
            3'd4:    e.r = a & ~b;
            3'd5:    e.r = a | ~b;
            3'd6:    e.r = ~(a ^ b);
            default: e.r = b;
        endcase
        e.z = (e.r == '0);
        e.n = e.r[DW-1];
        e.t = t;
        return e;
    endfunction

    task automatic drive(input logic [2:0] op, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic [TW-1:0] t);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = t;
    endtask

    function automatic logic [DW-1:0] rnd_word();
        return {$urandom(), $urandom()};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pop before push so a same-cycle acceptance can never satisfy its own check.
    always @(negedge clk) begin
        acc_now = rst_n && in_valid && in_ready;
        if (rst_n && prev_stall)
            chk("stall_hold", 128'({out_valid, out_result, out_zero, out_neg, out_tag}),
                128'(prev_out));
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output actual tag=%0h required=no output", out_tag);
            end else begin
                mon_e = exp_q.pop_front();
                chk("sb_result", 128'(out_result), 128'(mon_e.r));
                chk("sb_zero",   128'(out_zero),   128'(mon_e.z));
                chk("sb_neg",    128'(out_neg),    128'(mon_e.n));
                chk("sb_tag",    128'(out_tag),    128'(mon_e.t));
            end
            n_out++;
            log_tag.push_back(out_tag);
            log_cyc.push_back(cyc);
        end
        if (acc_now) begin
            exp_q.push_back(model(in_op, in_a, in_b, in_tag));
            n_acc++;
        end
        prev_stall = rst_n && out_valid && !out_ready;
        prev_out   = {out_valid, out_result, out_zero, out_neg, out_tag};
    end

    initial begin
        int   acc;
        int   n_before;
        int   sent;
        int   budget;
        int   w;
        logic got;
        logic [DW+TW+2:0] snap;
        logic [DW-1:0] a;
        logic [DW-1:0] b;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_op = '0; in_tag = '0;
        snap = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready",   128'(in_ready),   128'(0));
        chk("rst_out_valid",  128'(out_valid),  128'(0));
        chk("rst_out_result", 128'(out_result), 128'(0));
        chk("rst_out_zero",   128'(out_zero),   128'(1));
        chk("rst_out_neg",    128'(out_neg),    128'(0));
        chk("rst_out_tag",    128'(out_tag),    128'(0));

        // OR case issued together with reset release; exactly two cycles of latency.
        @(posedge clk); #1;
        rst_n = 1'b1; out_ready = 1'b1;
        drive(3'd1, 64'hF0F0_0000_0000_00FF, 64'h0FF0_0000_0000_0F0F, 4'd9);
        @(negedge clk);
        chk("first_accept_ready", 128'(in_ready), 128'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat1_out_valid", 128'(out_valid), 128'(0));
        @(negedge clk);
        chk("lat2_out_valid", 128'(out_valid),  128'(1));
        chk("or_result",      128'(out_result), 128'(64'hFFF0_0000_0000_0FFF));
        chk("or_zero",        128'(out_zero),   128'(0));
        chk("or_neg",         128'(out_neg),    128'(1));
        chk("or_tag",         128'(out_tag),    128'(9));

        // XOR to zero, then EON to all ones, back to back.
        @(posedge clk); #1;
        drive(3'd2, 64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_FFFF, 4'd1);
        @(posedge clk); #1;
        drive(3'd6, 64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_FFFF, 4'd2);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("xor_result", 128'(out_result), 128'(0));
        chk("xor_zero",   128'(out_zero),   128'(1));
        chk("xor_neg",    128'(out_neg),    128'(0));
        @(negedge clk);
        chk("eon_result", 128'(out_result), 128'({DW{1'b1}}));
        chk("eon_zero",   128'(out_zero),   128'(0));
        chk("eon_neg",    128'(out_neg),    128'(1));

        // Eight ops, one per cycle: results must stream out on consecutive cycles in order.
        repeat (3) @(posedge clk);
        #1;
        log_tag.delete();
        log_cyc.delete();
        for (int i = 0; i < 8; i++) begin
            drive(3'(i), rnd_word(), rnd_word(), TW'(i));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("b2b_count", 128'(log_tag.size()), 128'(8));
        if (log_tag.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                chk("b2b_tag", 128'(log_tag[i]), 128'(i));
                chk("b2b_cycle", 128'(log_cyc[i] - log_cyc[0]), 128'(i));
            end
        end

        // Back-pressure: only two accepted, outputs frozen, then both delivered.
        n_before = n_out;
        out_ready = 1'b0;
        acc = 0;
        drive(3'd5, rnd_word(), rnd_word(), 4'hA);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            got = in_valid && in_ready;
            if (got) acc++;
            if (c >= 3) chk("full_in_ready", 128'(in_ready), 128'(0));
            if (c == 3) begin
                chk("full_out_valid", 128'(out_valid), 128'(1));
                snap = {out_valid, out_result, out_zero, out_neg, out_tag};
            end
            if (c == 5)
                chk("full_hold", 128'({out_valid, out_result, out_zero, out_neg, out_tag}),
                    128'(snap));
            @(posedge clk); #1;
            if (got) drive(3'(c + 2), rnd_word(), rnd_word(), TW'(c + 10));
        end
        chk("full_accepts", 128'(acc), 128'(2));
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("full_delivered", 128'(n_out - n_before), 128'(2));

        // Reset with two operations in flight: both must vanish.
        out_ready = 1'b0;
        drive(3'd0, rnd_word(), rnd_word(), 4'd3);
        @(posedge clk); #1;
        drive(3'd3, rnd_word(), rnd_word(), 4'd4);
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("mid_rst_in_ready", 128'(in_ready), 128'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete();
        n_acc = 0;
        n_out = 0;
        @(negedge clk);
        chk("post_rst_valid", 128'(out_valid), 128'(0));
        chk("post_rst_tag",   128'(out_tag),   128'(0));
        chk("post_rst_zero",  128'(out_zero),  128'(1));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_quiet", 128'(out_valid), 128'(0));
        end

        // Random valid/ready traffic; a presented op is held until it is accepted.
        @(posedge clk); #1;
        sent = 0;
        budget = 0;
        while (sent < NOPS && budget < 60000) begin
            if (in_valid && acc_now) sent++;
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid || acc_now) begin
                if (sent < NOPS && $urandom_range(0, 3) != 0) begin
                    case ($urandom_range(0, 3))
                        0: begin a = rnd_word(); b = a; end
                        1: begin a = '0; b = {DW{1'b1}}; end
                        default: begin a = rnd_word(); b = rnd_word(); end
                    endcase
                    drive(3'($urandom_range(0, 7)), a, b, TW'($urandom()));
                end else begin
                    in_valid = 1'b0;
                end
            end
            @(posedge clk); #1;
            budget++;
        end
        if (in_valid && acc_now) sent++;
        in_valid = 1'b0;
        chk("random_sent", 128'(sent), 128'(NOPS));

        out_ready = 1'b1;
        w = 0;
        while (exp_q.size() != 0 && w < 50) begin
            @(posedge clk);
            w++;
        end
        #1;
        chk("drain_empty", 128'(exp_q.size()), 128'(0));
        chk("in_out_count", 128'(n_out), 128'(n_acc));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
